// File: rtl/dmem_pkg.sv
// Shared memory parameters: word geometry and access-type encodings used by
// the data memory and any instruction memory.
package dmem_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    BYTE = 2'b01,
    WORD = 2'b10,
    HALF = 2'b11
  } acc_e;

endpackage

// File: rtl/dmem_load_fmt.sv
// Load extractor: picks the byte/half/word lane of a stored word and
// sign-extends it to the full data width; zero when disabled or str=NONE.
module dmem_load_fmt #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [1:0]       str_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);
  import dmem_pkg::*;

  always_comb begin
    data_o = '0;
    if (en_i) begin
      case (str_i)
        WORD:    data_o = word_i;
        HALF:    data_o = {{(WIDTH-16){word_i[15]}}, word_i[15:0]};
        BYTE:    data_o = {{(WIDTH-8){word_i[7]}}, word_i[7:0]};
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem.sv
// Data memory: word-addressed DEPTH x WIDTH array with synchronous
// byte/half/word stores, combinational sign-extending loads, async clear.
module dmem #(
  parameter int WIDTH = dmem_pkg::WIDTH,
  parameter int DEPTH = dmem_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] daddr,
  input  logic [WIDTH-1:0] indata,
  input  logic [1:0]       stw,
  input  logic [1:0]       str,
  output logic [WIDTH-1:0] outdata
);
  import dmem_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0]    idx;
  logic             in_range;
  logic [WIDTH-1:0] words [DEPTH];
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] wr_word_d;
  logic             we;

  // Only the low index bits address the array; any set upper bit is out of range.
  assign idx      = daddr[AW-1:0];
  assign in_range = (daddr[WIDTH-1:AW] == '0) && ({1'b0, idx} < DEPTH_W);
  assign rd_word  = words[idx];

  always_comb begin
    wr_word_d = rd_word;
    we        = 1'b0;
    case (stw)
      WORD: begin
        wr_word_d = indata;
        we        = in_range;
      end
      HALF: begin
        wr_word_d[15:0] = indata[15:0];
        we              = in_range;
      end
      BYTE: begin
        wr_word_d[7:0] = indata[7:0];
        we             = in_range;
      end
      default: we = 1'b0;
    endcase
  end

  // One register per word so the whole array clears asynchronously at once.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
      end else if (we && (idx == AW'(g))) begin
        word_q <= wr_word_d;
      end
    end

    assign words[g] = word_q;
  end

  dmem_load_fmt #(
    .WIDTH (WIDTH)
  ) u_load_fmt (
    .word_i (rd_word),
    .str_i  (str),
    .en_i   (in_range && rst_n),
    .data_o (outdata)
  );

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem: fill, lane merges, same-cycle
// store/load ordering, asynchronous clear and address range handling.
module tb_dmem;
  localparam int WIDTH = 32;
  localparam int DEPTH = 256;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] daddr;
  logic [WIDTH-1:0] indata;
  logic [1:0]       stw;
  logic [1:0]       str;
  logic [WIDTH-1:0] outdata;

  int checks = 0;
  int errors = 0;

  dmem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .daddr   (daddr),
    .indata  (indata),
    .stw     (stw),
    .str     (str),
    .outdata (outdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fill_word(int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] exp);
    checks++;
    assert (outdata === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, outdata, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    @(negedge clk);
    daddr  = a;
    indata = d;
    stw    = t;
    str    = 2'b00;
    @(posedge clk);
    #1;
    stw = 2'b00;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] t,
                    input logic [31:0] exp, input string tag);
    daddr = a;
    str   = t;
    #1;
    chk(tag, exp);
  endtask

  initial begin
    rst_n  = 1'b1;
    daddr  = '0;
    indata = '0;
    stw    = 2'b00;
    str    = 2'b00;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd(32'd0, 2'b10, 32'h0, "reset_word0");
    rd(32'd17, 2'b01, 32'h0, "reset_byte17");
    @(negedge clk);
    rst_n = 1'b1;

    // word fill and readback
    for (int i = 0; i < 30; i++) wr(32'(i), fill_word(i), 2'b10);
    for (int i = 0; i < 30; i++) rd(32'(i), 2'b10, fill_word(i), $sformatf("fill_%0d", i));

    // byte merge
    wr(32'd5, 32'h11223344, 2'b10);
    rd(32'd5, 2'b01, 32'h00000044, "byte_pos_read");
    rd(32'd5, 2'b11, 32'h00003344, "half_pos_read");
    wr(32'd5, 32'hAABBCCF0, 2'b01);
    rd(32'd5, 2'b01, 32'hFFFFFFF0, "byte_merge_sx");
    rd(32'd5, 2'b10, 32'h112233F0, "byte_merge_word");

    // half merge
    wr(32'd6, 32'h11223344, 2'b10);
    wr(32'd6, 32'h00008001, 2'b11);
    rd(32'd6, 2'b11, 32'hFFFF8001, "half_merge_sx");
    rd(32'd6, 2'b10, 32'h11228001, "half_merge_word");

    // stw=00 leaves memory alone
    wr(32'd6, 32'hFFFFFFFF, 2'b00);
    rd(32'd6, 2'b10, 32'h11228001, "store_none");

    // same-cycle store and load, no bypass
    wr(32'd7, 32'h1, 2'b10);
    @(negedge clk);
    daddr  = 32'd7;
    indata = 32'h2;
    stw    = 2'b10;
    str    = 2'b10;
    #1 chk("same_cycle_before", 32'h1);
    @(posedge clk);
    #1 chk("same_cycle_after", 32'h2);
    stw = 2'b00;

    // range boundary and out-of-range
    wr(32'd255, 32'hA5A5_5A5A, 2'b10);
    rd(32'd255, 2'b10, 32'hA5A5_5A5A, "last_word");
    wr(32'(DEPTH), 32'h5, 2'b10);
    rd(32'd0, 2'b10, fill_word(0), "oor_no_alias0");
    wr(32'h8000_0005, 32'h5, 2'b10);
    rd(32'd5, 2'b10, 32'h112233F0, "oor_no_alias5");
    rd(32'(DEPTH), 2'b10, 32'h0, "oor_read");
    rd(32'hFFFF_FFFF, 2'b01, 32'h0, "oor_read_top");
    rd(32'd5, 2'b00, 32'h0, "str_none");

    // asynchronous reset mid-sequence
    wr(32'd3, 32'hDEADBEEF, 2'b10);
    rd(32'd3, 2'b10, 32'hDEADBEEF, "pre_reset");
    #1 rst_n = 1'b0;
    rd(32'd3, 2'b10, 32'h0, "async_clear");
    rd(32'd5, 2'b10, 32'h0, "async_clear_other");
    daddr  = 32'd3;
    indata = 32'h77;
    stw    = 2'b10;
    @(posedge clk);
    #1 stw = 2'b00;
    rd(32'd3, 2'b10, 32'h0, "store_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("after_release", 32'h0);
    wr(32'd3, 32'hCAFEF00D, 2'b10);
    rd(32'd3, 2'b10, 32'hCAFEF00D, "first_store");
    rd(32'd29, 2'b10, 32'h0, "fill_discarded");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
